// File: rtl/non_rest_div_pipe.sv
// Iterative non-restoring divider, unsigned or signed (truncating), retiring
// BITS_PER_CYCLE quotient bits per clock behind a start/ready handshake.
module non_rest_div_pipe #(
    parameter int WIDTH          = 256,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             dz
);

    localparam int N  = WIDTH / BITS_PER_CYCLE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_ITER,
        S_FIX,
        S_DONE
    } state_t;

    state_t           state_reg;
    logic [CW-1:0]    cnt_reg;
    logic [WIDTH-1:0] dvd_reg;
    logic [WIDTH-1:0] dvs_reg;
    logic             sm_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] d_reg;
    logic [WIDTH:0]   p_reg;
    logic [WIDTH-1:0] q_reg;
    logic             q_neg_reg;
    logic             r_neg_reg;
    logic             dz_flag_reg;
    logic             busy_reg;
    logic             ready_reg;
    logic [WIDTH-1:0] quotient_reg;
    logic [WIDTH-1:0] remainder_reg;
    logic             dz_reg;

    // Operand conditioning: magnitudes are only taken in signed mode.
    logic             dvd_neg;
    logic             dvs_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] d_mag;

    assign dvd_neg = sm_reg & dvd_reg[WIDTH-1];
    assign dvs_neg = sm_reg & dvs_reg[WIDTH-1];
    assign a_mag   = dvd_neg ? -dvd_reg : dvd_reg;
    assign d_mag   = dvs_neg ? -dvs_reg : dvs_reg;

    // BITS_PER_CYCLE chained non-restoring steps on a WIDTH+1-bit remainder.
    // Intermediate doubling may wrap, but every post-step value lies in
    // [-d, d) and therefore fits, so modular arithmetic stays exact.
    logic [WIDTH:0]   d_ext;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   p_next;
    logic [WIDTH-1:0] a_next;
    logic [WIDTH-1:0] q_next;

    assign d_ext = {1'b0, d_reg};

    always_comb begin
        shifted = '0;
        p_next  = p_reg;
        a_next  = a_reg;
        q_next  = q_reg;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            shifted = {p_next[WIDTH-1:0], a_next[WIDTH-1]};
            if (p_next[WIDTH]) begin
                p_next = shifted + d_ext;
            end else begin
                p_next = shifted - d_ext;
            end
            a_next = {a_next[WIDTH-2:0], 1'b0};
            q_next = {q_next[WIDTH-2:0], ~p_next[WIDTH]};
        end
    end

    // Final correction and sign application; the remainder's low WIDTH bits
    // are all that survive, so the correction add is done at WIDTH bits.
    logic [WIDTH-1:0] r_mag;
    logic [WIDTH-1:0] q_signed;
    logic [WIDTH-1:0] r_signed;

    assign r_mag    = p_reg[WIDTH] ? (p_reg[WIDTH-1:0] + d_reg) : p_reg[WIDTH-1:0];
    assign q_signed = q_neg_reg ? -q_reg : q_reg;
    assign r_signed = r_neg_reg ? -r_mag : r_mag;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= S_IDLE;
            cnt_reg       <= '0;
            dvd_reg       <= '0;
            dvs_reg       <= '0;
            sm_reg        <= 1'b0;
            a_reg         <= '0;
            d_reg         <= '0;
            p_reg         <= '0;
            q_reg         <= '0;
            q_neg_reg     <= 1'b0;
            r_neg_reg     <= 1'b0;
            dz_flag_reg   <= 1'b0;
            busy_reg      <= 1'b0;
            ready_reg     <= 1'b0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
            dz_reg        <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        dvd_reg     <= dividend;
                        dvs_reg     <= divisor;
                        sm_reg      <= signed_mode;
                        dz_flag_reg <= 1'b0;
                        busy_reg    <= 1'b1;
                        ready_reg   <= 1'b0;
                        state_reg   <= S_PREP;
                    end
                end
                S_PREP: begin
                    a_reg     <= a_mag;
                    d_reg     <= d_mag;
                    p_reg     <= '0;
                    q_reg     <= '0;
                    q_neg_reg <= dvd_neg ^ dvs_neg;
                    r_neg_reg <= dvd_neg;
                    if (dvs_reg == '0) begin
                        dz_flag_reg <= 1'b1;
                        state_reg   <= S_FIX;
                    end else begin
                        cnt_reg   <= CW'(N - 1);
                        state_reg <= S_ITER;
                    end
                end
                S_ITER: begin
                    p_reg <= p_next;
                    a_reg <= a_next;
                    q_reg <= q_next;
                    if (cnt_reg == '0) begin
                        state_reg <= S_FIX;
                    end else begin
                        cnt_reg <= cnt_reg - CW'(1);
                    end
                end
                S_FIX: begin
                    if (dz_flag_reg) begin
                        quotient_reg  <= '1;
                        remainder_reg <= dvd_reg;
                        dz_reg        <= 1'b1;
                    end else begin
                        quotient_reg  <= q_signed;
                        remainder_reg <= r_signed;
                        dz_reg        <= 1'b0;
                    end
                    busy_reg  <= 1'b0;
                    ready_reg <= 1'b1;
                    state_reg <= S_DONE;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_reg;
    assign ready     = ready_reg;
    assign quotient  = quotient_reg;
    assign remainder = remainder_reg;
    assign dz        = dz_reg;

endmodule

// File: tb/tb_non_rest_div_pipe.sv
// Bench for non_rest_div_pipe: directed 32-bit vectors and handshake/reset
// sequences, then random 256-bit traffic against an arithmetic reference.
`timescale 1ns/1ps
module tb_non_rest_div_pipe;

    localparam int W   = 32;
    localparam int BPC = 2;
    localparam int N32 = W / BPC;
    localparam int SW  = 256;
    localparam int NV  = 13;

    logic         clk;
    logic         rst;
    logic         start;
    logic         signed_mode;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         ready;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         dz;

    int   checks;
    int   errors;
    logic go;
    int   done_cnt;

    non_rest_div_pipe #(.WIDTH(W), .BITS_PER_CYCLE(BPC)) u_dut32 (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .signed_mode(signed_mode),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .ready      (ready),
        .quotient   (quotient),
        .remainder  (remainder),
        .dz         (dz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [SW-1:0] act, input logic [SW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference: plain integer division on a sign-extended operand so that
    // MIN / -1 cannot overflow before truncation back to SW bits.
    function automatic void ref_div(input logic sm, input logic [SW-1:0] a, input logic [SW-1:0] b,
                                    output logic [SW-1:0] q, output logic [SW-1:0] r, output logic z);
        logic signed [SW:0] sa;
        logic signed [SW:0] sb;
        logic signed [SW:0] sq;
        logic signed [SW:0] sr;
        if (b == '0) begin
            q = '1;
            r = a;
            z = 1'b1;
        end else if (!sm) begin
            q = a / b;
            r = a % b;
            z = 1'b0;
        end else begin
            sa = {a[SW-1], a};
            sb = {b[SW-1], b};
            sq = sa / sb;
            sr = sa % sb;
            q  = sq[SW-1:0];
            r  = sr[SW-1:0];
            z  = 1'b0;
        end
    endfunction

    function automatic logic [SW-1:0] pick_val(input int unsigned kind);
        logic [SW-1:0] v;
        for (int j = 0; j < SW / 32; j++) v[j*32 +: 32] = $urandom;
        case (kind)
            0: v = '0;
            1: v = SW'(1);
            2: v = {1'b1, {(SW-1){1'b0}}};
            3: v = '1;
            4: v = v >> $urandom_range(SW - 1, 0);
            5: v = '0 - SW'($urandom_range(40, 1));
            6: v = SW'($urandom_range(1000, 2));
            default: ;
        endcase
        return v;
    endfunction

    task automatic run32(input logic sm, input logic [W-1:0] a, input logic [W-1:0] b,
                         output int lat, output logic hs_ok, output logic busy_ok);
        signed_mode = sm;
        dividend    = a;
        divisor     = b;
        start       = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start   = 1'b0;
        hs_ok   = busy && !ready;
        busy_ok = 1'b1;
        lat     = 0;
        do begin
            if (!busy) busy_ok = 1'b0;
            @(posedge clk);
            @(negedge clk);
            lat++;
        end while (!ready && lat < N32 + 8);
        if (busy) busy_ok = 1'b0;
    endtask

    typedef struct {
        logic         sm;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
        int           lat;
    } vec_t;

    vec_t tv [NV];

    initial begin : main
        int   lat;
        logic hs;
        logic bok;

        tv[0]  = '{1'b0, 32'd100,        32'd10,         32'd10,         32'd0,          1'b0, N32 + 2};
        tv[1]  = '{1'b1, 32'hFFFFFF85,   32'd7,          32'hFFFFFFEF,   32'hFFFFFFFC,   1'b0, N32 + 2};
        tv[2]  = '{1'b1, 32'd123,        32'hFFFFFFF9,   32'hFFFFFFEF,   32'd4,          1'b0, N32 + 2};
        tv[3]  = '{1'b0, 32'd123,        32'd7,          32'd17,         32'd4,          1'b0, N32 + 2};
        tv[4]  = '{1'b0, 32'd55,         32'd0,          32'hFFFFFFFF,   32'd55,         1'b1, 2};
        tv[5]  = '{1'b1, 32'd55,         32'd0,          32'hFFFFFFFF,   32'd55,         1'b1, 2};
        tv[6]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          1'b0, N32 + 2};
        tv[7]  = '{1'b0, 32'h80000000,   32'hFFFFFFFF,   32'd0,          32'h80000000,   1'b0, N32 + 2};
        tv[8]  = '{1'b0, 32'd5,          32'd9,          32'd0,          32'd5,          1'b0, N32 + 2};
        tv[9]  = '{1'b1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF,   1'b0, N32 + 2};
        tv[10] = '{1'b1, 32'hFFFFFFF9,   32'hFFFFFFFE,   32'd3,          32'hFFFFFFFF,   1'b0, N32 + 2};
        tv[11] = '{1'b0, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0,          1'b0, N32 + 2};
        tv[12] = '{1'b1, 32'hFFFFFFC9,   32'd0,          32'hFFFFFFFF,   32'hFFFFFFC9,   1'b1, 2};

        checks = 0;
        errors = 0;
        go = 1'b0;
        done_cnt = 0;
        rst = 1'b0;
        start = 1'b0;
        signed_mode = 1'b0;
        dividend = '0;
        divisor = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset busy", SW'(busy), SW'(0));
        check("reset ready", SW'(ready), SW'(0));
        check("reset dz", SW'(dz), SW'(0));
        check("reset quotient", SW'(quotient), SW'(0));
        check("reset remainder", SW'(remainder), SW'(0));
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < NV; i++) begin
            run32(tv[i].sm, tv[i].a, tv[i].b, lat, hs, bok);
            check($sformatf("vec%0d latency", i), SW'(lat), SW'(tv[i].lat));
            check($sformatf("vec%0d start handshake", i), SW'(hs), SW'(1));
            check($sformatf("vec%0d busy window", i), SW'(bok), SW'(1));
            check($sformatf("vec%0d quotient", i), SW'(quotient), SW'(tv[i].q));
            check($sformatf("vec%0d remainder", i), SW'(remainder), SW'(tv[i].r));
            check($sformatf("vec%0d dz", i), SW'(dz), SW'(tv[i].z));
            $display("vec %0d: sm=%0d %h / %h -> q=%h r=%h dz=%0d lat=%0d",
                     i, tv[i].sm, tv[i].a, tv[i].b, quotient, remainder, dz, lat);
        end

        // A second start pulse during iteration must not disturb the division.
        signed_mode = 1'b0;
        dividend = 32'd100;
        divisor = 32'd10;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        repeat (5) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        dividend = 32'd7;
        divisor = 32'd2;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        lat++;
        start = 1'b0;
        while (!ready && lat < N32 + 8) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        check("ignored start latency", SW'(lat), SW'(N32 + 2));
        check("ignored start quotient", SW'(quotient), SW'(10));
        check("ignored start remainder", SW'(remainder), SW'(0));
        $display("seq ignored-start: q=%h r=%h lat=%0d", quotient, remainder, lat);

        // Asynchronous reset in the middle of an iteration.
        signed_mode = 1'b0;
        dividend = 32'd100;
        divisor = 32'd10;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("pre-reset busy", SW'(busy), SW'(1));
        #2 rst = 1'b0;
        #1;
        check("async reset busy", SW'(busy), SW'(0));
        check("async reset ready", SW'(ready), SW'(0));
        check("async reset dz", SW'(dz), SW'(0));
        check("async reset quotient", SW'(quotient), SW'(0));
        check("async reset remainder", SW'(remainder), SW'(0));
        $display("seq async-reset: busy=%0d ready=%0d q=%h r=%h", busy, ready, quotient, remainder);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        run32(1'b0, 32'd123, 32'd7, lat, hs, bok);
        check("post-reset latency", SW'(lat), SW'(N32 + 2));
        check("post-reset quotient", SW'(quotient), SW'(17));
        check("post-reset remainder", SW'(remainder), SW'(4));
        $display("seq post-reset: q=%h r=%h lat=%0d", quotient, remainder, lat);

        go = 1'b1;
        for (int c = 0; c < 90000 && done_cnt < 3; c++) @(posedge clk);
        check("random traffic completed", SW'(done_cnt), SW'(3));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_stress
            localparam int SBPC = 1 << gi;
            localparam int SN   = SW / SBPC;
            localparam int NOPS = (gi == 0) ? 150 : ((gi == 1) ? 300 : 600);

            logic          s_start;
            logic          s_sm;
            logic [SW-1:0] s_a;
            logic [SW-1:0] s_b;
            logic          s_busy;
            logic          s_ready;
            logic [SW-1:0] s_q;
            logic [SW-1:0] s_r;
            logic          s_dz;

            non_rest_div_pipe #(.WIDTH(SW), .BITS_PER_CYCLE(SBPC)) u_dut (
                .clk        (clk),
                .rst        (rst),
                .start      (s_start),
                .signed_mode(s_sm),
                .dividend   (s_a),
                .divisor    (s_b),
                .busy       (s_busy),
                .ready      (s_ready),
                .quotient   (s_q),
                .remainder  (s_r),
                .dz         (s_dz)
            );

            initial begin : stim
                logic [SW-1:0] eq;
                logic [SW-1:0] er;
                logic          ez;
                logic          hs;
                int            lat;
                s_start = 1'b0;
                s_sm = 1'b0;
                s_a = '0;
                s_b = '0;
                wait (go);
                @(negedge clk);
                for (int i = 0; i < NOPS; i++) begin
                    s_sm = 1'($urandom_range(1, 0));
                    s_a = pick_val($urandom_range(9, 0));
                    s_b = pick_val($urandom_range(9, 0));
                    ref_div(s_sm, s_a, s_b, eq, er, ez);
                    s_start = 1'b1;
                    @(posedge clk);
                    @(negedge clk);
                    s_start = 1'b0;
                    hs = s_busy && !s_ready;
                    lat = 0;
                    do begin
                        @(posedge clk);
                        @(negedge clk);
                        lat++;
                    end while (!s_ready && lat < SN + 8);
                    check($sformatf("bpc%0d op%0d handshake", SBPC, i), SW'(hs), SW'(1));
                    check($sformatf("bpc%0d op%0d latency", SBPC, i), SW'(lat), SW'(ez ? 2 : SN + 2));
                    check($sformatf("bpc%0d op%0d quotient", SBPC, i), s_q, eq);
                    check($sformatf("bpc%0d op%0d remainder", SBPC, i), s_r, er);
                    check($sformatf("bpc%0d op%0d dz", SBPC, i), SW'(s_dz), SW'(ez));
                    $display("bpc%0d op %0d: sm=%0d dz=%0d lat=%0d q=%h", SBPC, i, s_sm, s_dz, lat, s_q);
                end
                done_cnt++;
            end
        end
    endgenerate

endmodule
